pixel_compositor: RTL
=====================

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 The block SHALL take parameter NUM_LAYERS, default 4, as the number of sprite/background layers (range 2..16).
REQ-002 The block SHALL take parameter COLOR_W, default 12, as the width of one RGB colour word.
REQ-003 The block SHALL take parameter BLANK_COLOR, default 12'h000, as the colour driven when blanking or when no layer is on.
REQ-004 The block SHALL have port clk, input, 1, the single pixel clock.
REQ-005 The block SHALL have port clrn, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port video_on, input, 1, the visible-area flag aligned with the layer inputs.
REQ-007 The block SHALL have port frame_start, input, 1, a one-cycle pulse on the first pixel of each frame.
REQ-008 The block SHALL have port layer_on, input, NUM_LAYERS, the per-layer pixel-on flags.
REQ-009 The block SHALL have port layer_color, input, NUM_LAYERS x COLOR_W, the per-layer colours.
REQ-010 The block SHALL have port prio_wr, input, 1, the priority-table write strobe.
REQ-011 The block SHALL have port prio_slot, input, IDX_W, the slot written, where IDX_W = max(1, clog2(NUM_LAYERS)) and slot 0 is the highest priority.
REQ-012 The block SHALL have port prio_layer, input, IDX_W, the layer index stored in that slot.
REQ-013 The block SHALL have port rgb, output, COLOR_W, the composited pixel.
REQ-014 The block SHALL have port top_layer, output, IDX_W, the index of the winning layer (0 when none).
REQ-015 The block SHALL have port top_valid, output, 1, which is high when some layer won the pixel.
REQ-016 The block SHALL have port coll, output, NUM_LAYERS x NUM_LAYERS, the latched pairwise collision matrix for the previous frame.
REQ-017 The block SHALL have port coll_valid, output, 1, a one-cycle pulse when coll is updated.

Function
REQ-018 The pipeline SHALL be 2 cycles: inputs are registered in stage 1, and priority selection is registered into rgb/top_layer/top_valid in stage 2.
REQ-019 In stage 2, the winner SHALL be the first slot s, scanning s = 0..NUM_LAYERS-1, with layer_on[active_tbl[s]] set; rgb SHALL equal that layer's colour.
REQ-020 If video_on was low for the pixel, or no slot matches, rgb SHALL be BLANK_COLOR and top_valid SHALL be 0.
REQ-021 A layer absent from active_tbl SHALL never be displayed; a duplicate entry SHALL be harmless, with the first match winning.
REQ-022 A prio_wr write SHALL update shadow_tbl[prio_slot] on the next edge; active_tbl SHALL copy shadow_tbl only on the cycle frame_start is sampled.
REQ-023 When prio_wr and frame_start occur in the same cycle, the commit SHALL include that same-cycle write.
REQ-024 A prio_layer value of NUM_LAYERS or greater SHALL be stored but SHALL never match any layer.
REQ-025 In stage 1, for every pair i<j with both layer_on set and video_on high, the accumulator bit acc[i][j] SHALL be set; bits with i>=j SHALL remain 0.
REQ-026 On stage-1 frame_start, coll SHALL load acc (the previous frame's result), coll_valid SHALL pulse one cycle later, and acc SHALL restart containing only the current pixel's overlaps.
REQ-027 Back-to-back frame_start pulses SHALL each latch and clear, with no lost or stale bits.

Reset
REQ-028 While clrn is low, rgb SHALL be BLANK_COLOR and top_layer, top_valid, coll, coll_valid, acc and all pipeline registers SHALL be 0.
REQ-029 While clrn is low, shadow_tbl[k] and active_tbl[k] SHALL be k, giving identity priority so that layer 0 is on top.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; the first valid output SHALL appear 2 cycles after release.

Structure
REQ-031 A shared package SHALL hold the default BLANK_COLOR constant, the colour word typedef, and the IDX_W derivation function.
REQ-032 The block SHALL contain one sub-module, prio_select, which is combinational and maps active_tbl plus the stage-1 flags and colours to a winner index, a valid flag and a colour.

Verification
REQ-033 With reset priorities, layer_on = 4'b0011, colours 12'hF00 and 12'h0F0, and video_on = 1, the bench SHALL see rgb = 12'hF00, top_layer = 0 and top_valid = 1 exactly 2 cycles later.
REQ-034 When slot 0 is written with layer 1 mid-frame, the output SHALL stay 12'hF00 until the frame_start commit, then change to 12'h0F0.
REQ-035 With prio_wr and frame_start in the same cycle, the new table SHALL apply to that frame's first pixel.
REQ-036 With layers 0 and 2 overlapping for one pixel in frame N, the next frame_start SHALL give coll[0][2] = 1 and all other bits 0, with coll_valid pulsing once; an empty frame N+1 SHALL then latch all zeros.
REQ-037 With video_on = 0 and all layers on, rgb SHALL be BLANK_COLOR, top_valid = 0, and no collision SHALL be recorded.
REQ-038 With clrn asserted mid-stream, outputs SHALL go to reset values immediately, and the table SHALL return to identity.

Source files
------------

// File: rtl/pixel_compositor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_compositor_pkg
// Description : Shared definitions for the pixel compositor. Provides the
//               default blanking colour, the default-width colour word type
//               and the layer-index width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_compositor_pkg;

    // Colour word at the default 12-bit RGB width (4:4:4).
    typedef logic [11:0] color_t;

    // Colour driven while blanking or when no layer claims the pixel.
    localparam color_t c_blank_color_default = 12'h000;

    // Width of a layer index. Never below one bit, so a two-layer
    // build still has a usable index port.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_select.sv
`default_nettype none
// ============================================================================
// Module      : prio_select
// Description : Combinational priority selector. Scans the priority table
//               from slot 0 (highest) downwards and picks the first layer
//               whose pixel-on flag is set.
//   i_active_tbl  : slot -> layer index table
//   i_video_on    : visible-area flag for this pixel
//   i_layer_on    : per-layer pixel-on flags
//   i_layer_color : per-layer colours
//   o_idx         : winning layer index (0 when none)
//   o_valid       : a layer won the pixel
//   o_color       : winning colour, or BLANK_COLOR
// Revision    : 1.0 - initial release
// ============================================================================
module prio_select
    import pixel_compositor_pkg::*;
#(
    parameter int                 NUM_LAYERS  = 4,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = COLOR_W'(c_blank_color_default),
    parameter int                 IDX_W       = idx_w(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0][IDX_W-1:0]   i_active_tbl,
    input  logic                               i_video_on,
    input  logic [NUM_LAYERS-1:0]              i_layer_on,
    input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] i_layer_color,
    output logic [IDX_W-1:0]                   o_idx,
    output logic                               o_valid,
    output logic [COLOR_W-1:0]                 o_color
);

    logic [IDX_W-1:0] w_cand;

    // First match wins, so duplicate table entries are harmless. Entries
    // naming a non-existent layer are skipped, which also keeps a layer
    // that is absent from the table from ever being shown.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        o_color = BLANK_COLOR;
        w_cand  = '0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            w_cand = i_active_tbl[s];
            if (!o_valid && i_video_on && (int'(w_cand) < NUM_LAYERS)
                && i_layer_on[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
                o_color = i_layer_color[w_cand];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module      : pixel_compositor
// Description : Two-stage layer compositor with a double-buffered priority
//               table and a per-frame pairwise collision matrix.
//   clk         : pixel clock
//   clrn        : asynchronous active-low reset
//   video_on    : visible-area flag, aligned with the layer inputs
//   frame_start : one-cycle pulse on the first pixel of a frame
//   layer_on    : per-layer pixel-on flags
//   layer_color : per-layer colours
//   prio_wr     : priority-table write strobe
//   prio_slot   : slot written (slot 0 is highest priority)
//   prio_layer  : layer index stored in that slot
//   rgb         : composited pixel (2-cycle latency)
//   top_layer   : winning layer index (0 when none)
//   top_valid   : a layer won the pixel
//   coll        : collision matrix of the previous frame, coll[i][j] for i<j
//   coll_valid  : one-cycle pulse when coll is reloaded
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int                 NUM_LAYERS  = 4,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = COLOR_W'(c_blank_color_default),
    localparam int                IDX_W       = idx_w(NUM_LAYERS)
) (
    input  logic                                  clk,
    input  logic                                  clrn,
    input  logic                                  video_on,
    input  logic                                  frame_start,
    input  logic [NUM_LAYERS-1:0]                 layer_on,
    input  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    layer_color,
    input  logic                                  prio_wr,
    input  logic [IDX_W-1:0]                      prio_slot,
    input  logic [IDX_W-1:0]                      prio_layer,
    output logic [COLOR_W-1:0]                    rgb,
    output logic [IDX_W-1:0]                      top_layer,
    output logic                                  top_valid,
    output logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] coll,
    output logic                                  coll_valid
);

    // ------------------------------------------------------------------
    // Priority tables
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0][IDX_W-1:0] r_shadow_tbl;
    logic [NUM_LAYERS-1:0][IDX_W-1:0] r_active_tbl;
    logic [NUM_LAYERS-1:0][IDX_W-1:0] w_shadow_next;

    // The commit copies the post-write shadow so a write landing in the
    // frame_start cycle takes effect for that frame's first pixel. Slots
    // beyond the table (non power-of-two layer counts) are ignored.
    always_comb begin
        w_shadow_next = r_shadow_tbl;
        if (prio_wr && (int'(prio_slot) < NUM_LAYERS)) begin
            w_shadow_next[prio_slot] = prio_layer;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                r_shadow_tbl[k] <= IDX_W'(k);
                r_active_tbl[k] <= IDX_W'(k);
            end
        end else begin
            r_shadow_tbl <= w_shadow_next;
            if (frame_start) begin
                r_active_tbl <= w_shadow_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: input registers
    // ------------------------------------------------------------------
    logic                               r_s1_video_on;
    logic                               r_s1_frame_start;
    logic [NUM_LAYERS-1:0]              r_s1_layer_on;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] r_s1_layer_color;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_s1_video_on    <= 1'b0;
            r_s1_frame_start <= 1'b0;
            r_s1_layer_on    <= '0;
            r_s1_layer_color <= '0;
        end else begin
            r_s1_video_on    <= video_on;
            r_s1_frame_start <= frame_start;
            r_s1_layer_on    <= layer_on;
            r_s1_layer_color <= layer_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority selection
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_valid;
    logic [COLOR_W-1:0] w_sel_color;
    logic [COLOR_W-1:0] r_rgb;
    logic [IDX_W-1:0]   r_top_layer;
    logic               r_top_valid;

    prio_select #(
        .NUM_LAYERS  (NUM_LAYERS),
        .COLOR_W     (COLOR_W),
        .BLANK_COLOR (BLANK_COLOR),
        .IDX_W       (IDX_W)
    ) u_prio_select (
        .i_active_tbl  (r_active_tbl),
        .i_video_on    (r_s1_video_on),
        .i_layer_on    (r_s1_layer_on),
        .i_layer_color (r_s1_layer_color),
        .o_idx         (w_sel_idx),
        .o_valid       (w_sel_valid),
        .o_color       (w_sel_color)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rgb       <= BLANK_COLOR;
            r_top_layer <= '0;
            r_top_valid <= 1'b0;
        end else begin
            r_rgb       <= w_sel_color;
            r_top_layer <= w_sel_idx;
            r_top_valid <= w_sel_valid;
        end
    end

    // ------------------------------------------------------------------
    // Collision accumulation (upper triangle only, i<j)
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] w_pair;
    logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] r_acc;
    logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] r_coll;
    logic                                  r_coll_valid;

    always_comb begin
        w_pair = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                w_pair[i][j] = r_s1_video_on & r_s1_layer_on[i] & r_s1_layer_on[j];
            end
        end
    end

    // On a frame boundary the finished frame is latched and the
    // accumulator restarts from the boundary pixel itself, so nothing
    // from that pixel is lost and nothing stale carries over.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_acc        <= '0;
            r_coll       <= '0;
            r_coll_valid <= 1'b0;
        end else if (r_s1_frame_start) begin
            r_coll       <= r_acc;
            r_acc        <= w_pair;
            r_coll_valid <= 1'b1;
        end else begin
            r_acc        <= r_acc | w_pair;
            r_coll_valid <= 1'b0;
        end
    end

    assign rgb        = r_rgb;
    assign top_layer  = r_top_layer;
    assign top_valid  = r_top_valid;
    assign coll       = r_coll;
    assign coll_valid = r_coll_valid;

endmodule
`default_nettype wire
